// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants, loader state encoding and bit-reverse helper
//               for the FFT input loader.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 256;
    localparam int FFT_LOG2N = 8;
    localparam int FFT_DW    = 16;

    typedef enum logic [0:0] {
        LDR_IDLE   = 1'b0,
        LDR_STREAM = 1'b1
    } loader_state_e;

    // Reverses the low log2n bits of k; bits above log2n come back as zero.
    function automatic logic [7:0] bitrev(input logic [7:0] k, input int log2n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < log2n) begin
                r[3'(log2n - 1 - i)] = k[i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_loader_if
// Description : Sample-write side from the Avalon slave plus the valid/ready
//               stream towards the FFT core.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_loader_if #(
    parameter int DW = 16,
    parameter int AW = 9
);
    logic          sWriteEn;
    logic [AW-1:0] wAddress;
    logic [DW-1:0] fft_init_data;
    logic          fft_start;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          overrun;

    modport master (
        output sWriteEn, wAddress, fft_init_data, fft_start, out_ready,
        input  out_data, out_valid, out_last, busy, overrun
    );

    modport slave (
        input  sWriteEn, wAddress, fft_init_data, fft_start, out_ready,
        output out_data, out_valid, out_last, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fft_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_sample_ram
// Description : Simple dual-port sample RAM, one write port and one
//               registered read port; address is {bank, index}.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_sample_ram #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // No reset on the array or read register so the tools map it to block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_loader
// Description : Ping-pong sample buffer that streams a captured frame to the
//               FFT core in bit-reversed order over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW,
    parameter int AW    = 9
) (
    input logic         clk,
    input logic         rst,
    fft_loader_if.slave bus
);

    localparam logic [0:0]       c_ST_IDLE   = LDR_IDLE;
    localparam logic [0:0]       c_ST_STREAM = LDR_STREAM;
    localparam logic [LOG2N-1:0] c_K_LAST    = LOG2N'(N - 1);
    localparam logic [AW-1:0]    c_N_ADDR    = AW'(N);

    logic [0:0]       r_state;
    logic             r_fill_bank;
    logic             r_stream_bank;
    logic             r_start_pending;
    logic [LOG2N-1:0] r_k;
    logic             r_issue_done;
    logic             r_overrun;

    logic             r_rd_pend;
    logic             r_rd_last;
    logic             r_out_valid;
    logic             r_out_last;
    logic [DW-1:0]    r_out_data;
    logic             r_skid_valid;
    logic             r_skid_last;
    logic [DW-1:0]    r_skid_data;

    logic             w_in_stream;
    logic             w_xfer;
    logic             w_last_xfer;
    logic [1:0]       w_occ;
    logic             w_issue;
    logic             w_wr_ok;
    logic             w_wr_drop;
    logic             w_start_drop;
    logic             w_swap;
    logic [7:0]       w_rev;
    logic [DW-1:0]    w_rd_data;

    assign w_in_stream = (r_state == c_ST_STREAM);
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_last_xfer = w_xfer && r_out_last;

    // Beats held in out, skid and the RAM read stage after this cycle's
    // transfer; a new read may only be issued while that stays below two.
    assign w_occ   = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_pend) - 2'(w_xfer);
    assign w_issue = w_in_stream && !r_issue_done && (w_occ < 2'd2);

    assign w_wr_ok      = bus.sWriteEn && (bus.wAddress < c_N_ADDR) && !r_start_pending;
    assign w_wr_drop    = bus.sWriteEn && !w_wr_ok;
    assign w_start_drop = w_in_stream && bus.fft_start && r_start_pending;
    assign w_swap       = (!w_in_stream && bus.fft_start) ||
                          (w_in_stream && w_last_xfer && (r_start_pending || bus.fft_start));

    assign w_rev = bitrev(8'(r_k), LOG2N);

    fft_sample_ram #(
        .DW (DW),
        .AW (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok && !rst),
        .i_waddr ({r_fill_bank, bus.wAddress[LOG2N-1:0]}),
        .i_wdata (bus.fft_init_data),
        .i_re    (w_issue),
        .i_raddr ({r_stream_bank, w_rev[LOG2N-1:0]}),
        .o_rdata (w_rd_data)
    );

    // Control: bank swap, frame sequencing, pending start and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_fill_bank     <= 1'b0;
            r_stream_bank   <= 1'b0;
            r_start_pending <= 1'b0;
            r_k             <= '0;
            r_issue_done    <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_wr_drop || w_start_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_swap) begin
                r_stream_bank   <= r_fill_bank;
                r_fill_bank     <= ~r_fill_bank;
                r_state         <= c_ST_STREAM;
                r_k             <= '0;
                r_issue_done    <= 1'b0;
                r_start_pending <= 1'b0;
            end else begin
                if (w_in_stream && w_last_xfer) begin
                    r_state <= c_ST_IDLE;
                end
                if (w_in_stream && bus.fft_start) begin
                    r_start_pending <= 1'b1;
                end
                if (w_issue) begin
                    if (r_k == c_K_LAST) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
            end
        end
    end

    // Datapath: RAM result lands in the output register, or in the skid
    // register when the output is stalled; skid always drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend    <= 1'b0;
            r_rd_last    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_rd_pend <= w_issue;
            r_rd_last <= w_issue && (r_k == c_K_LAST);
            if (!r_out_valid || w_xfer) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= r_rd_pend;
                    r_skid_data  <= w_rd_data;
                    r_skid_last  <= r_rd_last;
                end else if (r_rd_pend) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_rd_data;
                    r_out_last  <= r_rd_last;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end else if (r_rd_pend) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_rd_data;
                r_skid_last  <= r_rd_last;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = w_in_stream || r_start_pending;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_loader
// Description : Self-checking bench for fft_input_loader with N=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_loader;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
        logic        exp_ovr;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ref_edge = -1;
    int   xfer_cnt = 0;
    int   mode = 0;
    int   rcnt = 0;
    bit   mon_en = 1'b0;
    bit   prev_stall = 1'b0;
    bit   prev_valid = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    exp_t        q[$];
    logic [15:0] model_mem [2][8];
    int          model_fill = 0;

    fft_loader_if #(.DW(16), .AW(9)) bus ();

    fft_input_loader #(
        .N     (8),
        .LOG2N (3),
        .DW    (16),
        .AW    (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int brev3(input int k);
        return {k[0], k[1], k[2]};
    endfunction

    // out_ready pattern: mode 0 always ready, mode 1 cycles 1,0,0,1.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            if (mode == 0) bus.out_ready = 1'b1;
            else           bus.out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        end
    end

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && !prev_valid && ref_edge >= 0) begin
                chk("first_valid_latency", cyc - ref_edge, 2);
                ref_edge = -1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", bus.out_data, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                    xfer_cnt++;
                    if (e.last) ref_edge = cyc + 1;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_valid = bus.out_valid;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic write(input logic [8:0] addr, input logic [15:0] data);
        bus.sWriteEn      = 1'b1;
        bus.wAddress      = addr;
        bus.fft_init_data = data;
        if (addr < 9'd8) model_mem[model_fill][addr[2:0]] = data;
        @(posedge clk);
        #1;
        bus.sWriteEn = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 8; i++) write(9'(i), 16'(base + i));
    endtask

    // dup=1 models a start that must be ignored (already pending).
    task automatic pulse_start(input bit from_idle, input bit dup);
        if (!dup) begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                e.data = model_mem[model_fill][brev3(k)];
                e.last = (k == 7);
                q.push_back(e);
            end
            model_fill ^= 1;
        end
        bus.fft_start = 1'b1;
        @(posedge clk);
        #1;
        bus.fft_start = 1'b0;
        if (from_idle) ref_edge = cyc;
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while (q.size() > 0 && i < max) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_remaining", q.size(), 0);
    endtask

    initial begin
        wr_vec_t tbl [4];
        tbl[0] = '{9'd7,   16'h0077, 1'b0};
        tbl[1] = '{9'd8,   16'hBEEF, 1'b1};
        tbl[2] = '{9'h100, 16'hDEAD, 1'b1};
        tbl[3] = '{9'd5,   16'h0055, 1'b1};

        rst = 1'b1;
        bus.sWriteEn = 1'b0;
        bus.wAddress = '0;
        bus.fft_init_data = '0;
        bus.fft_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_out_data", bus.out_data, 16'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Fill and stream, always ready.
        mode = 0;
        fill(10);
        pulse_start(1'b1, 1'b0);
        drain(100);
        repeat (3) @(posedge clk);
        #1;
        chk("fs_busy_idle", bus.busy, 1'b0);
        chk("fs_valid_idle", bus.out_valid, 1'b0);

        // Backpressure on the same data.
        mode = 1;
        fill(10);
        pulse_start(1'b1, 1'b0);
        drain(200);

        // Ping-pong: refill the other bank while frame A streams.
        fill(0);
        pulse_start(1'b1, 1'b0);
        fill(100);
        chk("pp_busy_during", bus.busy, 1'b1);
        pulse_start(1'b0, 1'b0);
        drain(300);
        repeat (3) @(posedge clk);
        #1;
        chk("pp_overrun", bus.overrun, 1'b0);
        chk("pp_busy_idle", bus.busy, 1'b0);

        // Errors: table of writes, including out-of-range addresses.
        mode = 0;
        for (int i = 0; i < 4; i++) begin
            write(tbl[i].addr, tbl[i].data);
            chk("tbl_overrun", bus.overrun, tbl[i].exp_ovr);
        end
        pulse_start(1'b1, 1'b0);
        pulse_start(1'b0, 1'b0);
        pulse_start(1'b0, 1'b1);
        drain(300);
        repeat (30) @(posedge clk);
        #1;
        chk("err_overrun_sticky", bus.overrun, 1'b1);
        chk("err_busy_idle", bus.busy, 1'b0);
        chk("err_no_extra_frame", q.size(), 0);

        // Reset during beat 3 of a frame.
        xfer_cnt = 0;
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 50 && xfer_cnt < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_reached_beat3", xfer_cnt, 3);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid_out_valid", bus.out_valid, 1'b0);
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_overrun", bus.overrun, 1'b0);
        chk("rstmid_out_last", bus.out_last, 1'b0);
        q.delete();
        model_fill = 0;
        ref_edge = -1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        fill(200);
        pulse_start(1'b1, 1'b0);
        drain(100);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_overrun", bus.overrun, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
